// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, sync, blanking, strobes.
// Ports: clk, rst (async, active-high), ce, restart -> hpos, vpos, hsync,
//        vsync, display_on, line_start, frame_start, frame_count.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int FRAME_W   = 8,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               restart,
    output logic [HW-1:0]      hpos,
    output logic [VW-1:0]      vpos,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        FRAME_W < 1) begin : g_bad_param
        $error("vga_timing_gen: timing parameters must be >= 1");
    end

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam logic HS_ACT = (HSYNC_POL != 0);
    localparam logic VS_ACT = (VSYNC_POL != 0);

    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic          ls_nxt;
    logic          fs_nxt;
    logic          fc_inc;
    logic          h_wrap;
    logic          v_wrap;

    // Next position and strobes; sync/blank below are derived from the
    // next position so the registered outputs line up with hpos/vpos.
    always_comb begin
        h_nxt  = hpos;
        v_nxt  = vpos;
        ls_nxt = 1'b0;
        fs_nxt = 1'b0;
        fc_inc = 1'b0;
        h_wrap = (hpos == H_LAST);
        v_wrap = (vpos == V_LAST);
        if (restart) begin
            h_nxt  = '0;
            v_nxt  = '0;
            ls_nxt = 1'b1;
            fs_nxt = 1'b1;
        end else if (ce) begin
            if (h_wrap) begin
                h_nxt  = '0;
                ls_nxt = 1'b1;
                if (v_wrap) begin
                    v_nxt  = '0;
                    fs_nxt = 1'b1;
                    fc_inc = 1'b1;
                end else begin
                    v_nxt = vpos + 1'b1;
                end
            end else begin
                h_nxt = hpos + 1'b1;
            end
        end
    end

    logic hs_nxt;
    logic vs_nxt;
    logic de_nxt;

    always_comb begin
        hs_nxt = ~HS_ACT;
        vs_nxt = ~VS_ACT;
        if (32'(h_nxt) >= HS_START && 32'(h_nxt) < HS_END)
            hs_nxt = HS_ACT;
        if (32'(v_nxt) >= VS_START && 32'(v_nxt) < VS_END)
            vs_nxt = VS_ACT;
        de_nxt = (32'(h_nxt) < H_ACTIVE) && (32'(v_nxt) < V_ACTIVE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hpos        <= '0;
            vpos        <= '0;
            hsync       <= ~HS_ACT;
            vsync       <= ~VS_ACT;
            display_on  <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            hpos        <= h_nxt;
            vpos        <= v_nxt;
            hsync       <= hs_nxt;
            vsync       <= vs_nxt;
            display_on  <= de_nxt;
            line_start  <= ls_nxt;
            frame_start <= fs_nxt;
            if (fc_inc)
                frame_count <= frame_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing plus a tiny
// 8x6 configuration for full-frame, sync and frame_count wrap checks.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst, ce, restart, ce2, restart2;

    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       hsync, vsync, display_on, line_start, frame_start;
    logic [7:0] frame_count;

    logic [2:0] hpos2;
    logic [2:0] vpos2;
    logic       hsync2, vsync2, disp2, ls2, fs2;
    logic [1:0] fc2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut (
        .clk(clk), .rst(rst), .ce(ce), .restart(restart),
        .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
        .display_on(display_on), .line_start(line_start),
        .frame_start(frame_start), .frame_count(frame_count)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .FRAME_W(2)
    ) dut_s (
        .clk(clk), .rst(rst), .ce(ce2), .restart(restart2),
        .hpos(hpos2), .vpos(vpos2), .hsync(hsync2), .vsync(vsync2),
        .display_on(disp2), .line_start(ls2),
        .frame_start(fs2), .frame_count(fc2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic adv(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int ls_cnt;
    int ls_at[2];
    int wide;
    logic ls_prev;

    initial begin
        rst = 1'b1; ce = 1'b0; restart = 1'b0;
        ce2 = 1'b0; restart2 = 1'b0;
        #3;
        chk("rst_hpos", 32'(hpos), 0);
        chk("rst_vpos", 32'(vpos), 0);
        chk("rst_fc", 32'(frame_count), 0);
        chk("rst_ls", 32'(line_start), 0);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_disp", 32'(display_on), 1);
        chk("rst_hsync", 32'(hsync), 1);
        chk("rst_vsync", 32'(vsync), 1);
        #9;
        rst = 1'b0;
        adv(1);
        chk("idle_hpos", 32'(hpos), 0);
        chk("idle_ls", 32'(line_start), 0);
        chk("idle_fs", 32'(frame_start), 0);

        // Small config: 8 pixels x 6 lines = 48 edges per frame.
        ce2 = 1'b1;
        adv(3);
        chk("s_disp_n3", 32'(disp2), 1);
        adv(1);
        chk("s_disp_n4", 32'(disp2), 0);
        chk("s_hs_n4", 32'(hsync2), 1);
        adv(1);
        chk("s_hs_n5", 32'(hsync2), 0);
        adv(2);
        chk("s_hs_n7", 32'(hsync2), 1);
        adv(17);
        chk("s_v_n24", 32'(vpos2), 3);
        chk("s_disp_n24", 32'(disp2), 0);
        adv(7);
        chk("s_vs_n31", 32'(vsync2), 1);
        adv(1);
        chk("s_vs_n32", 32'(vsync2), 0);
        adv(8);
        chk("s_vs_n40", 32'(vsync2), 1);
        chk("s_v_n40", 32'(vpos2), 5);
        chk("s_ls_n40", 32'(ls2), 1);
        adv(7);
        chk("s_fs_n47", 32'(fs2), 0);
        chk("s_fc_n47", 32'(fc2), 0);
        adv(1);
        chk("s_fs_n48", 32'(fs2), 1);
        chk("s_fc_n48", 32'(fc2), 1);
        chk("s_h_n48", 32'(hpos2), 0);
        chk("s_v_n48", 32'(vpos2), 0);
        adv(48);
        chk("s_fc_n96", 32'(fc2), 2);
        adv(48);
        chk("s_fc_n144", 32'(fc2), 3);
        adv(20);
        chk("s_h_n164", 32'(hpos2), 4);
        chk("s_v_n164", 32'(vpos2), 2);
        restart2 = 1'b1;
        adv(1);
        restart2 = 1'b0;
        chk("s_rs_h", 32'(hpos2), 0);
        chk("s_rs_v", 32'(vpos2), 0);
        chk("s_rs_ls", 32'(ls2), 1);
        chk("s_rs_fs", 32'(fs2), 1);
        chk("s_rs_fc", 32'(fc2), 3);
        adv(48);
        chk("s_wrap_fs", 32'(fs2), 1);
        chk("s_wrap_fc", 32'(fc2), 0);
        ce2 = 1'b0;

        // Default instance held with ce=0 throughout the above.
        chk("hold_hpos", 32'(hpos), 0);
        chk("hold_ls", 32'(line_start), 0);

        ce = 1'b1;
        adv(639);
        chk("disp_h639", 32'(display_on), 1);
        adv(1);
        chk("h640", 32'(hpos), 640);
        chk("disp_h640", 32'(display_on), 0);
        adv(15);
        chk("hs_h655", 32'(hsync), 1);
        adv(1);
        chk("hs_h656", 32'(hsync), 0);
        adv(95);
        chk("hs_h751", 32'(hsync), 0);
        adv(1);
        chk("hs_h752", 32'(hsync), 1);
        adv(47);
        chk("h799", 32'(hpos), 799);
        chk("ls_h799", 32'(line_start), 0);
        adv(1);
        chk("wrap_h", 32'(hpos), 0);
        chk("wrap_v", 32'(vpos), 1);
        chk("wrap_ls", 32'(line_start), 1);
        chk("wrap_fs", 32'(frame_start), 0);
        chk("wrap_disp", 32'(display_on), 1);
        adv(1);
        chk("ls_width", 32'(line_start), 0);
        adv(1);
        ce = 1'b0;
        adv(1);
        chk("ce0_hold", 32'(hpos), 2);

        // Alternate ce: line period doubles to 1600 cycles.
        ls_cnt = 0;
        wide = 0;
        ls_prev = 1'b0;
        for (int i = 0; i < 3400; i++) begin
            ce = (i % 2 == 0);
            adv(1);
            if (line_start && ls_prev)
                wide++;
            if (line_start) begin
                if (ls_cnt < 2)
                    ls_at[ls_cnt] = i;
                ls_cnt++;
            end
            ls_prev = line_start;
        end
        chk("tog_ls_cnt", 32'(ls_cnt), 2);
        chk("tog_period", 32'(ls_at[1] - ls_at[0]), 1600);
        chk("tog_wide", 32'(wide), 0);
        chk("tog_h", 32'(hpos), 102);
        chk("tog_v", 32'(vpos), 3);

        ce = 1'b1;
        adv(198);
        chk("pre_rs_h", 32'(hpos), 300);
        restart = 1'b1;
        adv(1);
        chk("rs_h", 32'(hpos), 0);
        chk("rs_v", 32'(vpos), 0);
        chk("rs_ls", 32'(line_start), 1);
        chk("rs_fs", 32'(frame_start), 1);
        chk("rs_fc", 32'(frame_count), 0);
        adv(1);
        chk("rs2_h", 32'(hpos), 0);
        chk("rs2_ls", 32'(line_start), 1);
        chk("rs2_fs", 32'(frame_start), 1);
        restart = 1'b0;
        adv(1);
        chk("post_rs_h", 32'(hpos), 1);
        chk("post_rs_fs", 32'(frame_start), 0);
        adv(700);
        chk("pre_arst_h", 32'(hpos), 701);

        // Asynchronous reset pulse entirely between two edges.
        #1;
        rst = 1'b1;
        #1;
        chk("arst_h", 32'(hpos), 0);
        chk("arst_disp", 32'(display_on), 1);
        chk("arst_hs", 32'(hsync), 1);
        rst = 1'b0;
        adv(1);
        chk("arst_run_h", 32'(hpos), 1);
        chk("arst_run_ls", 32'(line_start), 0);
        chk("arst_run_fs", 32'(frame_start), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL: parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL: parameter H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch in pixels.
REQ-003 SHALL: parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 SHALL: parameter V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch in lines.
REQ-005 SHALL: parameter HSYNC_POL / VSYNC_POL, 0 / 0, active level of hsync / vsync (0 = active-low).
REQ-006 SHALL: parameter FRAME_W, 8, frame_count width.
REQ-007 SHALL: derived H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; HW = clog2(H_TOTAL), VW = clog2(V_TOTAL) (defaults 800/525, 10/10).
REQ-008 SHALL: clk  input  1  single clock; all state is updated on its rising edge.
REQ-009 SHALL: rst  input  1  asynchronous, active-high reset.
REQ-010 SHALL: ce  input  1  pixel-advance enable.
REQ-011 SHALL: restart  input  1  synchronous jump to the frame origin.
REQ-012 SHALL: hpos  output  HW  current pixel column.
REQ-013 SHALL: vpos  output  VW  current line.
REQ-014 SHALL: hsync, vsync  output  1 each  sync outputs.
REQ-015 SHALL: display_on  output  1  high inside the active area.
REQ-016 SHALL: line_start, frame_start  output  1 each  single-cycle strobes.
REQ-017 SHALL: frame_count  output  FRAME_W  completed-frame counter.

Function
REQ-018 SHALL: every output is a register; in any cycle, hsync/vsync/display_on describe the hpos/vpos presented in that same cycle.
REQ-019 SHALL: when ce=1 and restart=0, hpos increments by 1 each edge.
REQ-020 SHALL: at hpos=H_TOTAL-1, hpos wraps to 0 and vpos increments; at vpos=V_TOTAL-1, vpos also wraps to 0.
REQ-021 SHALL: when ce=0 and restart=0, all counters hold and no strobe is asserted.
REQ-022 SHALL: display_on = (hpos < H_ACTIVE) && (vpos < V_ACTIVE).
REQ-023 SHALL: hsync = HSYNC_POL when H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL; vsync follows the same rule using the V_* parameters against vpos, independent of hpos.
REQ-024 SHALL: line_start is high for exactly one clk cycle, immediately after any edge at which hpos wrapped to 0 or restart was applied.
REQ-025 SHALL: frame_start is high for exactly one clk cycle, immediately after any edge at which both counters wrapped to 0 or restart was applied.
REQ-026 SHALL: frame_count increments modulo 2^FRAME_W on the same edge that vpos wraps from V_TOTAL-1 to 0.
REQ-027 SHALL: restart=1 has priority over ce: the next edge sets hpos=0 and vpos=0, pulses line_start and frame_start, and leaves frame_count unchanged.
REQ-028 SHALL: restart asserted on consecutive cycles holds hpos/vpos at 0, with both strobes high in each following cycle.
REQ-029 SHALL: restart latency is one edge; there is no other pipeline latency.
REQ-030 SHALL: any parameter value < 1 causes an elaboration-time error.

Reset
REQ-031 SHALL: while rst=1, independent of clk: hpos=0, vpos=0, frame_count=0, line_start=0, frame_start=0, display_on=1, hsync=~HSYNC_POL, vsync=~VSYNC_POL.
REQ-032 SHALL: after rst deasserts, counting begins at the first edge with ce=1, and no strobe is emitted for the reset origin.
REQ-033 SHALL: rst asserted mid-frame aborts the frame without incrementing frame_count.

Verification
REQ-034 SHALL: defaults, ce=1 -> display_on falls at hpos=640; hsync is low for hpos 656..751 only; vsync is low for vpos 490..491 only.
REQ-035 SHALL: defaults, ce=1 from reset -> first frame_start after 420000 edges, with frame_count 0->1 on that edge; line_start every 800 edges.
REQ-036 SHALL: ce toggling 1,0,1,0 -> line period 1600 clk cycles; hpos holds while ce=0; each strobe is exactly 1 cycle wide.
REQ-037 SHALL: restart at hpos=300, vpos=100, frame_count=5 -> next cycle hpos=0, vpos=0, line_start=1, frame_start=1, frame_count=5.
REQ-038 SHALL: rst pulsed between clk edges mid-frame -> all outputs reach reset values before the next edge.
REQ-039 SHALL: H=4/1/2/1, V=3/1/1/1, FRAME_W=2 -> frame period 48 edges; frame_count sequence 0,1,2,3,0.
